// File: rtl/im_loader.sv
// im_loader: boot-time instruction-memory writer.
// Receives a byte stream (16-bit little-endian word count, payload words,
// XOR checksum), writes little-endian 32-bit words into IM at consecutive
// word addresses, and holds the core in reset until a load finishes with
// a matching checksum.
// Optional build macro IM_LOADER_VERIFY_EN adds a read-back pass that
// re-derives the checksum from IM contents before declaring success.
module im_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              IM_enable_o,
    output logic              IM_write_o,
    output logic [ADDR_W-1:0] IM_address_o,
    output logic [31:0]       IM_in_o,
    input  logic [31:0]       IM_out_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              core_rst_n_o,
    output logic [15:0]       words_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CKSUM,
        S_DONE,
        S_ERR
`ifdef IM_LOADER_VERIFY_EN
        ,
        S_VRD,
        S_VCMP
`endif
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              xfer;
    logic [15:0]       len_rx;
    logic              len_too_big;
    logic              last_word;
    logic [ADDR_W-1:0] word_addr;

    logic [15:0]       count;
    logic [7:0]        cnt_lo;
    logic [1:0]        byte_idx;
    logic [15:0]       word_idx;
    logic [31:0]       word_buf;
    logic [7:0]        acc;
    logic              done_flag;
    logic              err_flag;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;

`ifdef IM_LOADER_VERIFY_EN
    logic [7:0]        cksum;
    logic [7:0]        vacc;
    logic [7:0]        vacc_next;
    logic [15:0]       r_idx;
    logic              last_read;
`else
    logic              unused_im_out;
`endif

    assign xfer        = rx_valid_i & rx_ready_o;
    // Full count as it stands when the high byte arrives in LEN1.
    assign len_rx      = {rx_data_i, cnt_lo};
    assign len_too_big = int'(len_rx) > MAX_WORDS;
    assign last_word   = (word_idx + 16'd1) == count;
    assign word_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);

`ifdef IM_LOADER_VERIFY_EN
    // Read data arrives one cycle after VRD, so it is folded in during VCMP.
    assign vacc_next = vacc ^ IM_out_i[7:0] ^ IM_out_i[15:8]
                            ^ IM_out_i[23:16] ^ IM_out_i[31:24];
    assign last_read = (r_idx + 16'd1) == count;
`else
    assign unused_im_out = ^IM_out_i;
`endif

    assign IM_address_o = addr;
    assign IM_in_o      = wdata;
    assign done_o       = done_flag;
    assign err_o        = err_flag;
    assign core_rst_n_o = done_flag;
    assign words_o      = count;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_next = S_LEN0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    state_next = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    if (len_too_big) begin
                        state_next = S_ERR;
                    end else if (len_rx == 16'd0) begin
                        state_next = S_CKSUM;
                    end else begin
                        state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer && byte_idx == 2'd3) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = last_word ? S_CKSUM : S_DATA;
            end
            S_CKSUM: begin
                if (xfer) begin
                    if (rx_data_i != acc) begin
                        state_next = S_ERR;
                    end else begin
`ifdef IM_LOADER_VERIFY_EN
                        state_next = (count == 16'd0) ? S_DONE : S_VRD;
`else
                        state_next = S_DONE;
`endif
                    end
                end
            end
`ifdef IM_LOADER_VERIFY_EN
            S_VRD: begin
                state_next = S_VCMP;
            end
            S_VCMP: begin
                if (!last_read) begin
                    state_next = S_VRD;
                end else begin
                    state_next = (vacc_next == cksum) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Per-state stream handshake, IM strobes and busy indication.
    always_comb begin
        rx_ready_o  = 1'b0;
        IM_enable_o = 1'b1;
        IM_write_o  = 1'b1;
        busy_o      = 1'b1;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                busy_o = 1'b0;
            end
            S_LEN0, S_LEN1, S_DATA, S_CKSUM: begin
                rx_ready_o = 1'b1;
            end
            S_WRITE: begin
                IM_enable_o = 1'b0;
                IM_write_o  = 1'b0;
            end
`ifdef IM_LOADER_VERIFY_EN
            S_VRD: begin
                IM_enable_o = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Control state: status flags, counters, checksum and IM address/data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            count     <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            acc       <= '0;
            addr      <= '0;
            wdata     <= '0;
`ifdef IM_LOADER_VERIFY_EN
            r_idx     <= '0;
            vacc      <= '0;
`endif
        end else begin
            // Flags are sticky until the next accepted start.
            if (state_next == S_DONE) begin
                done_flag <= 1'b1;
            end
            if (state_next == S_ERR) begin
                err_flag <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        done_flag <= 1'b0;
                        err_flag  <= 1'b0;
                        acc       <= '0;
                    end
                end
                S_LEN0: begin
                    if (xfer) begin
                        acc <= acc ^ rx_data_i;
                    end
                end
                S_LEN1: begin
                    if (xfer) begin
                        acc      <= acc ^ rx_data_i;
                        count    <= len_rx;
                        byte_idx <= '0;
                        word_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        acc      <= acc ^ rx_data_i;
                        byte_idx <= byte_idx + 2'd1;
                        // Present address and the completed word during WRITE.
                        if (byte_idx == 2'd3) begin
                            addr  <= word_addr;
                            wdata <= {rx_data_i, word_buf[23:0]};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                end
`ifdef IM_LOADER_VERIFY_EN
                S_CKSUM: begin
                    if (state_next == S_VRD) begin
                        r_idx <= '0;
                        vacc  <= count[7:0] ^ count[15:8];
                        addr  <= ADDR_W'(BASE_ADDR);
                    end
                end
                S_VCMP: begin
                    vacc  <= vacc_next;
                    r_idx <= r_idx + 16'd1;
                    if (state_next == S_VRD) begin
                        addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx + 16'd1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Payload staging: count low byte, word assembly and received checksum.
    always_ff @(posedge clk) begin
        if (state == S_LEN0 && xfer) begin
            cnt_lo <= rx_data_i;
        end
        if (state == S_DATA && xfer) begin
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_data_i;
        end
`ifdef IM_LOADER_VERIFY_EN
        if (state == S_CKSUM && xfer) begin
            cksum <= rx_data_i;
        end
`endif
    end

endmodule
